mic_rx_stereo: RTL and testbench
================================

// Module: mic_rx_stereo
// PURPOSE
//  Parametrised successor to the single-channel mic loader: deserialises CODEC ADC audio (ADCLRC/ADCDAT on BCLK)
//  for left and right channels, in left-justified or I2S framing, into N-bit words tagged with channel.
//  Words are buffered in a DEPTH-entry FIFO behind a valid/ready handshake.
//  Sits between the CODEC pins (CODEC configured over I2C) and downstream DSP/recording logic.
// PARAMETERS
//  N         16  sample width in bits, MSB-first; 4..32
//  I2S_MODE   0  0 = left-justified (MSB on the ADCLRC edge); 1 = I2S (MSB one BCLK after the edge)
//  STEREO     1  1 = capture both channels; 0 = left only (right frames ignored, no flags raised)
//  DEPTH      4  FIFO entries; power of two, >= 2
// PORTS
//  bclk         in   1              bit clock; the only clock; all logic on posedge
//  rst_n        in   1              synchronous active-low reset
//  adclrc       in   1              frame clock; rising edge = left word start, falling edge = right word start
//  adcdat       in   1              serial ADC data
//  out_ready    in   1              downstream accepts the head word
//  out_valid    out  1              FIFO non-empty
//  out_data     out  N              head word
//  out_channel  out  1              head word channel; 0 = left, 1 = right
//  fill_level   out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//  overflow     out  1              sticky: a completed word was dropped because the FIFO was full
//  frame_error  out  1              sticky: an ADCLRC edge arrived before N bits were captured
//  clear_flags  in   1              clears overflow and frame_error
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FIFO empty, out_valid=0, out_data=0, out_channel=0, fill_level=0,
//   overflow=0, frame_error=0, FSM=IDLE, bit counter=0, adclrc_q=adclrc. Reset wins over all else.
//  Edge detect: adclrc_q registered each posedge; rise = adclrc & ~adclrc_q, fall = ~adclrc & adclrc_q.
//   Let E = posedge where the edge is detected. The first capture after reset waits for an edge.
//  FSM: IDLE -> (edge) SHIFT if LJ, DELAY if I2S; DELAY -> SHIFT next cycle; SHIFT -> IDLE after bit N.
//   LJ: MSB captured at E, LSB at E+N-1. I2S: MSB at E+1, LSB at E+N.
//   Bit k (0 = MSB) stored into shift register bit N-1-k. Bits after the N-th ignored until next edge.
//  Completion: word + channel pushed on the posedge after the LSB (LJ: E+N; I2S: E+N+1);
//   out_valid rises right after that posedge when FIFO was empty (first-word latency N+1 / N+2 BCLK).
//  Edge while in DELAY/SHIFT: partial word discarded, frame_error<=1, new word starts from that edge
//   exactly as from IDLE (channel from the new edge).
//  STEREO=0: falling edges are ignored in IDLE and abort nothing; an in-flight left word still completes.
//  FIFO: pop when out_valid & out_ready at posedge. Push when word completes.
//   Full + push + pop same cycle: both occur, fill_level unchanged, no overflow.
//   Full + push, no pop: new word dropped, FIFO unchanged, overflow<=1.
//   Empty + push: out_valid=1 next cycle; push/pop cannot coincide on empty (nothing to pop).
//   Pointers wrap modulo DEPTH; out_data/out_channel hold stable while out_valid & ~out_ready.
//  Flags: clear_flags clears both; if a set event coincides with clear_flags, set wins.
//  No backpressure to the CODEC: capture never stalls; loss reported only via overflow.
// TESTING
//  1 LJ, N=16: left word 16'hA5C3, right 16'h1234, out_ready=1 -> out (A5C3,ch0) at E+16, (1234,ch1) next frame.
//  2 I2S_MODE=1: same stream delayed 1 BCLK -> identical words; LJ-timed stream gives words shifted by 1 bit.
//  3 out_ready=0, DEPTH=4, 5 words -> fill_level=4, overflow=1, head still word 1; drain -> words 1..4 in order.
//  4 Full with out_ready=1 on completion cycle -> no overflow, fill_level stays 4; clear_flags -> overflow=0.
//  5 ADCLRC toggles after 9 bits -> frame_error=1, partial word never output, next full word correct.
//  6 rst_n=0 mid-word for 2 cycles -> all outputs 0; first output is the word from the next edge only.

Source files
------------

// File: rtl/mic_rx_stereo.sv
// Deserialises CODEC ADC audio (LJ or I2S framing) into channel-tagged N-bit words behind a DEPTH-entry FIFO.
// First word visible N+1 (LJ) / N+2 (I2S) BCLK after the ADCLRC edge; capture never stalls, drops reported via overflow.
module mic_rx_stereo #(
  parameter int N        = 16,
  parameter int I2S_MODE = 0,
  parameter int STEREO   = 1,
  parameter int DEPTH    = 4
) (
  input  logic                   bclk,
  input  logic                   rst_n,
  input  logic                   adclrc,
  input  logic                   adcdat,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [N-1:0]           out_data,
  output logic                   out_channel,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic                   frame_error,
  input  logic                   clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sr_q, sr_d;
  logic           ch_q, ch_d;
  logic           adclrc_q;
  logic           pend_vld_q, pend_vld_d;
  logic [N-1:0]   pend_dat_q, pend_dat_d;
  logic           pend_ch_q, pend_ch_d;
  logic           rise, fall, edge_det, fe_set;

  logic [N:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           full, push, pop, wr_en, ovf_set;
  logic           overflow_q, frame_error_q;

  assign rise     = adclrc & ~adclrc_q;
  assign fall     = ~adclrc & adclrc_q;
  // In mono mode right-channel edges neither start nor abort a word.
  assign edge_det = rise | (fall & (STEREO != 0));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ch_d       = ch_q;
    pend_vld_d = 1'b0;
    pend_dat_d = pend_dat_q;
    pend_ch_d  = pend_ch_q;
    fe_set     = 1'b0;
    if (edge_det) begin
      fe_set = (state_q != IDLE);
      ch_d   = fall;
      if (I2S_MODE != 0) begin
        state_d = DELAY;
        cnt_d   = '0;
      end else begin
        sr_d    = {sr_q[N-2:0], adcdat};
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end
    end else begin
      case (state_q)
        DELAY: begin
          sr_d    = {sr_q[N-2:0], adcdat};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          sr_d = {sr_q[N-2:0], adcdat};
          if (cnt_q == CW'(N-1)) begin
            // Completed word is parked so a back-to-back edge can reuse sr_q.
            pend_vld_d = 1'b1;
            pend_dat_d = {sr_q[N-2:0], adcdat};
            pend_ch_d  = ch_q;
            state_d    = IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      ch_q       <= 1'b0;
      adclrc_q   <= adclrc;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      pend_ch_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ch_q       <= ch_d;
      adclrc_q   <= adclrc;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      pend_ch_q  <= pend_ch_d;
    end
  end

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push    = pend_vld_q;
  assign pop     = out_valid & out_ready;
  // A pop on the same edge frees the slot, so full+push+pop is not a drop.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {pend_ch_q, pend_dat_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop) count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (ovf_set) overflow_q <= 1'b1;
      else if (clear_flags) overflow_q <= 1'b0;
      if (fe_set) frame_error_q <= 1'b1;
      else if (clear_flags) frame_error_q <= 1'b0;
    end
  end

  assign out_valid                = (count_q != '0);
  assign {out_channel, out_data}  = mem_q[rd_ptr_q];
  assign fill_level               = count_q;
  assign overflow                 = overflow_q;
  assign frame_error              = frame_error_q;

endmodule

// File: tb/tb_mic_rx_stereo.sv
// Drives one serial stream into an LJ and an I2S instance side by side and checks words, timing, flags and reset.
module tb_mic_rx_stereo;

  logic        bclk = 1'b0;
  logic        rst_n, adclrc, adcdat, out_ready, clear_flags;
  logic        vld_lj, ch_lj, ovf_lj, fe_lj;
  logic        vld_is, ch_is, ovf_is, fe_is;
  logic [15:0] dat_lj, dat_is;
  logic [2:0]  fill_lj, fill_is;
  int          total = 0;
  int          bad = 0;
  int          lat_lj, lat_is;

  always #5 bclk = ~bclk;

  mic_rx_stereo #(.N(16), .I2S_MODE(0), .STEREO(1), .DEPTH(4)) dut_lj (
    .bclk(bclk), .rst_n(rst_n), .adclrc(adclrc), .adcdat(adcdat), .out_ready(out_ready),
    .out_valid(vld_lj), .out_data(dat_lj), .out_channel(ch_lj), .fill_level(fill_lj),
    .overflow(ovf_lj), .frame_error(fe_lj), .clear_flags(clear_flags));

  mic_rx_stereo #(.N(16), .I2S_MODE(1), .STEREO(1), .DEPTH(4)) dut_is (
    .bclk(bclk), .rst_n(rst_n), .adclrc(adclrc), .adcdat(adcdat), .out_ready(out_ready),
    .out_valid(vld_is), .out_data(dat_is), .out_channel(ch_is), .fill_level(fill_is),
    .overflow(ovf_is), .frame_error(fe_is), .clear_flags(clear_flags));

  typedef struct {
    logic [15:0] l, r;
    logic        i2s_t;
    logic [15:0] lj_l, lj_r, is_l, is_r;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // One half-frame of len BCLKs; i2s_t delays the MSB by one BCLK; pop_at >= 0 pulses out_ready on that cycle.
  task automatic frame(input logic lrc, input logic [15:0] w, input logic i2s_t, input int len, input int pop_at);
    lat_lj = -1;
    lat_is = -1;
    for (int k = 0; k < len; k++) begin
      int b;
      b = i2s_t ? k - 1 : k;
      adclrc = lrc;
      adcdat = (b >= 0 && b < 16) ? w[15-b] : 1'b0;
      if (pop_at >= 0) out_ready = (k == pop_at);
      tick();
      if (lat_lj < 0 && vld_lj) lat_lj = k;
      if (lat_is < 0 && vld_is) lat_is = k;
    end
    if (pop_at >= 0) out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{l:16'hA5C3, r:16'h1234, i2s_t:1'b0, lj_l:16'hA5C3, lj_r:16'h1234, is_l:16'h4B86, is_r:16'h2468};
    vecs[1] = '{l:16'hA5C3, r:16'h1234, i2s_t:1'b1, lj_l:16'h52E1, lj_r:16'h091A, is_l:16'hA5C3, is_r:16'h1234};
    vecs[2] = '{l:16'hFFFF, r:16'h0001, i2s_t:1'b0, lj_l:16'hFFFF, lj_r:16'h0001, is_l:16'hFFFE, is_r:16'h0002};
    vecs[3] = '{l:16'h8000, r:16'h7FFE, i2s_t:1'b1, lj_l:16'h4000, lj_r:16'h3FFF, is_l:16'h8000, is_r:16'h7FFE};

    rst_n = 1'b0; adclrc = 1'b0; adcdat = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
    repeat (3) tick();
    chk("rst_vld", vld_lj, 0);
    chk("rst_dat", dat_lj, 0);
    chk("rst_fill", fill_lj, 0);
    chk("rst_ovf", ovf_lj, 0);
    chk("rst_fe", fe_lj, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_word", vld_lj | vld_is, 0);

    for (int v = 0; v < 4; v++) begin
      frame(1'b1, vecs[v].l, vecs[v].i2s_t, 20, -1);
      chk($sformatf("v%0d_lat_lj", v), lat_lj, 16);
      chk($sformatf("v%0d_lat_is", v), lat_is, 17);
      frame(1'b0, vecs[v].r, vecs[v].i2s_t, 20, -1);
      chk($sformatf("v%0d_fill_lj", v), fill_lj, 2);
      chk($sformatf("v%0d_fill_is", v), fill_is, 2);
      chk($sformatf("v%0d_lj_l", v), {ch_lj, dat_lj}, {1'b0, vecs[v].lj_l});
      chk($sformatf("v%0d_is_l", v), {ch_is, dat_is}, {1'b0, vecs[v].is_l});
      pop1();
      chk($sformatf("v%0d_lj_r", v), {ch_lj, dat_lj}, {1'b1, vecs[v].lj_r});
      chk($sformatf("v%0d_is_r", v), {ch_is, dat_is}, {1'b1, vecs[v].is_r});
      pop1();
      chk($sformatf("v%0d_empty", v), {vld_lj, vld_is}, 0);
    end

    // Overflow: five words into a four-deep FIFO with no reader.
    frame(1'b1, 16'h1111, 1'b0, 20, -1);
    frame(1'b0, 16'h2222, 1'b0, 20, -1);
    frame(1'b1, 16'h3333, 1'b0, 20, -1);
    frame(1'b0, 16'h4444, 1'b0, 20, -1);
    chk("pre_ovf", ovf_lj, 0);
    frame(1'b1, 16'h5555, 1'b0, 20, -1);
    chk("ovf_fill", fill_lj, 4);
    chk("ovf_lj", ovf_lj, 1);
    chk("ovf_is", ovf_is, 1);
    chk("ovf_head", {ch_lj, dat_lj}, {1'b0, 16'h1111});
    chk("drain0", {ch_lj, dat_lj}, {1'b0, 16'h1111}); pop1();
    chk("drain1", {ch_lj, dat_lj}, {1'b1, 16'h2222}); pop1();
    chk("drain2", {ch_lj, dat_lj}, {1'b0, 16'h3333}); pop1();
    chk("drain3", {ch_lj, dat_lj}, {1'b1, 16'h4444}); pop1();
    chk("drain_empty", fill_lj, 0);
    chk("ovf_sticky", ovf_lj, 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("ovf_clr", {ovf_lj, ovf_is}, 0);

    // Full FIFO with a pop on the completion edge: no drop.
    frame(1'b0, 16'h6666, 1'b0, 20, -1);
    frame(1'b1, 16'h7777, 1'b0, 20, -1);
    frame(1'b0, 16'h8888, 1'b0, 20, -1);
    frame(1'b1, 16'h9999, 1'b0, 20, -1);
    chk("full_fill", fill_lj, 4);
    frame(1'b0, 16'hAAAA, 1'b0, 20, 16);
    chk("pp_fill_lj", fill_lj, 4);
    chk("pp_fill_is", fill_is, 4);
    chk("pp_ovf", {ovf_lj, ovf_is}, 0);
    chk("pp_d0", {ch_lj, dat_lj}, {1'b0, 16'h7777}); pop1();
    chk("pp_d1", {ch_lj, dat_lj}, {1'b1, 16'h8888}); pop1();
    chk("pp_d2", {ch_lj, dat_lj}, {1'b0, 16'h9999}); pop1();
    chk("pp_d3", {ch_lj, dat_lj}, {1'b1, 16'hAAAA}); pop1();
    pop1();

    // Frame error: ADCLRC toggles after 9 bits of a left word.
    frame(1'b1, 16'hBEEF, 1'b0, 9, -1);
    frame(1'b0, 16'hCAFE, 1'b0, 20, -1);
    chk("fe_lj", fe_lj, 1);
    chk("fe_is", fe_is, 1);
    chk("fe_fill_lj", fill_lj, 1);
    chk("fe_fill_is", fill_is, 1);
    chk("fe_word_lj", {ch_lj, dat_lj}, {1'b1, 16'hCAFE});
    chk("fe_word_is", {ch_is, dat_is}, {1'b1, 16'h95FC});

    // Reset mid-word with a word queued and a flag set.
    frame(1'b1, 16'h0F0F, 1'b0, 8, -1);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("mrst_vld", {vld_lj, vld_is}, 0);
    chk("mrst_dat", {ch_lj, dat_lj}, 0);
    chk("mrst_fill", fill_lj, 0);
    chk("mrst_flags", {ovf_lj, fe_lj, fe_is}, 0);
    rst_n = 1'b1;
    frame(1'b1, 16'hFFFF, 1'b0, 12, -1);
    chk("mrst_no_stale", {vld_lj, vld_is}, 0);
    frame(1'b0, 16'h5A5A, 1'b0, 20, -1);
    chk("mrst_fill_after", fill_lj, 1);
    chk("mrst_word_lj", {ch_lj, dat_lj}, {1'b1, 16'h5A5A});
    chk("mrst_word_is", {ch_is, dat_is}, {1'b1, 16'hB4B4});
    chk("mrst_fe", fe_lj, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
